// File: rtl/ddr_fifo_pkg.sv
// Shared constants for the DDR-RAM-backed synchronous FIFO controller.
// The read latency and output buffer depth are tied to the attached RAM macro.
package ddr_fifo_pkg;

    localparam int unsigned RAM_RD_LATENCY = 1;
    localparam int unsigned OUT_BUF_DEPTH  = 2;

    // Holds 0..OUT_BUF_DEPTH.
    typedef logic [1:0] buf_cnt_t;

    function automatic int unsigned count_ones(input logic [RAM_RD_LATENCY-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(RAM_RD_LATENCY); i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/ddr_sync_fifo_ctrl_if.sv
// Stream and RAM-port bundle of the FIFO controller.
// slave = controller view, master = surrounding system (source, sink and RAM).
interface ddr_sync_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
);
    logic [DATA_WIDTH-1:0]   s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic [DATA_WIDTH-1:0]   m_data;
    logic                    m_valid;
    logic                    m_ready;
    logic [ADDR_WIDTH+1:0]   level;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [ADDR_WIDTH-1:0]   ram_waddr;
    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_raddr;
    logic                    ram_re;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    modport slave (
        input  s_data, s_valid, m_ready, ram_rdata,
        output s_ready, m_data, m_valid, level,
               ram_wdata, ram_waddr, ram_we, ram_raddr, ram_re
    );

    modport master (
        output s_data, s_valid, m_ready, ram_rdata,
        input  s_ready, m_data, m_valid, level,
               ram_wdata, ram_waddr, ram_we, ram_raddr, ram_re
    );

endinterface

// File: rtl/ddr_fifo_out_buf.sv
// Two-entry first-word-fall-through buffer that absorbs RAM read data.
// Entry 0 is always the oldest word, so the output holds its last value once drained.
module ddr_fifo_out_buf
    import ddr_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  valid_o,
    output buf_cnt_t              buf_cnt_o
);

    logic [DATA_WIDTH-1:0] ent_q [OUT_BUF_DEPTH];
    logic [DATA_WIDTH-1:0] ent_d [OUT_BUF_DEPTH];
    buf_cnt_t              cnt_q, cnt_d;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned and infers a latch.
    always_comb begin
        ent_d = ent_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else begin
            case ({wr_en_i, rd_en_i})
                2'b10: begin
                    ent_d[cnt_q[0]] = wr_data_i;
                    cnt_d           = cnt_q + 2'd1;
                end
                2'b01: begin
                    if (cnt_q[1]) ent_d[0] = ent_q[1];
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q[1]) begin
                        ent_d[0] = ent_q[1];
                        ent_d[1] = wr_data_i;
                    end else begin
                        ent_d[0] = wr_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: these two entries are reset on purpose because the output data must read zero in reset; large RAM arrays would not be.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ent_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign rd_data_o = ent_q[0];
    assign valid_o   = (cnt_q != '0);
    assign buf_cnt_o = cnt_q;

endmodule

// File: rtl/ddr_sync_fifo_ctrl.sv
// FIFO controller in front of an external simple dual-port RAM with registered read data.
// Words are prefetched from RAM into a small output buffer to hide the read latency.
module ddr_sync_fifo_ctrl
    import ddr_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    ddr_sync_fifo_ctrl_if.slave  bus
);

    localparam int LEVEL_W = ADDR_WIDTH + 2;

    logic [ADDR_WIDTH-1:0]     wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0]     rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]       ram_cnt_q, ram_cnt_d;
    logic [RAM_RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic                      run_q;

    logic                      push, pop, prefetch, rdata_vld;
    int unsigned               inflight;
    buf_cnt_t                  buf_cnt;
    logic [DATA_WIDTH-1:0]     buf_data;
    logic                      buf_valid;

    // ram_cnt never exceeds DEPTH, so its MSB alone flags a full RAM.
    assign bus.s_ready = run_q && !ram_cnt_q[ADDR_WIDTH] && !clr;
    assign push        = bus.s_valid && bus.s_ready;
    assign pop         = buf_valid && bus.m_ready;
    assign inflight    = count_ones(rd_pipe_q);
    assign rdata_vld   = rd_pipe_q[RAM_RD_LATENCY-1];

    // Only fetch when the word is guaranteed a buffer slot on arrival.
    assign prefetch = (ram_cnt_q != '0) && !clr &&
                      ((32'(buf_cnt) + inflight) < (OUT_BUF_DEPTH + 32'(pop)));

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        ram_cnt_d = ram_cnt_q;
        rd_pipe_d = (rd_pipe_q << 1) | RAM_RD_LATENCY'(prefetch);
        if (clr) begin
            wptr_d    = '0;
            rptr_d    = '0;
            ram_cnt_d = '0;
            rd_pipe_d = '0;
        end else begin
            if (push)     wptr_d = wptr_q + ADDR_WIDTH'(1);
            if (prefetch) rptr_d = rptr_q + ADDR_WIDTH'(1);
            case ({push, prefetch})
                2'b10:   ram_cnt_d = ram_cnt_q + (ADDR_WIDTH+1)'(1);
                2'b01:   ram_cnt_d = ram_cnt_q - (ADDR_WIDTH+1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            ram_cnt_q <= '0;
            rd_pipe_q <= '0;
            run_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ram_cnt_q <= ram_cnt_d;
            rd_pipe_q <= rd_pipe_d;
            run_q     <= 1'b1;
        end
    end

    ddr_fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .rstn      (rstn),
        .clr_i     (clr),
        .wr_en_i   (rdata_vld && !clr),
        .wr_data_i (bus.ram_rdata),
        .rd_en_i   (pop),
        .rd_data_o (buf_data),
        .valid_o   (buf_valid),
        .buf_cnt_o (buf_cnt)
    );

    assign bus.ram_we    = push;
    assign bus.ram_waddr = wptr_q;
    assign bus.ram_wdata = push ? bus.s_data : '0;
    assign bus.ram_re    = prefetch;
    assign bus.ram_raddr = rptr_q;
    assign bus.m_data    = buf_data;
    assign bus.m_valid   = buf_valid;
    assign bus.level     = LEVEL_W'(ram_cnt_q) + LEVEL_W'(inflight) + LEVEL_W'(buf_cnt);

endmodule

// File: doc/ddr_sync_fifo_ctrl.md
DDR_SYNC_FIFO_CTRL -- requirements
Module: ddr_sync_fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload width in bits.
REQ-002 Parameter ADDR_WIDTH, default 9: RAM address width; DEPTH = 2**ADDR_WIDTH RAM entries.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 clr  input  1  synchronous flush; discards all contents.
REQ-006 s_data  input  DATA_WIDTH  write payload.
REQ-007 s_valid  input  1  write request.
REQ-008 s_ready  output  1  write accepted when s_valid && s_ready.
REQ-009 m_data  output  DATA_WIDTH  read payload, first-word-fall-through.
REQ-010 m_valid  output  1  m_data valid.
REQ-011 m_ready  input  1  read taken when m_valid && m_ready.
REQ-012 level  output  ADDR_WIDTH+2  items accepted and not yet taken.
REQ-013 ram_wdata / ram_waddr / ram_we  output  DATA_WIDTH / ADDR_WIDTH / 1  RAM write port.
REQ-014 ram_raddr / ram_re  output  ADDR_WIDTH / 1  RAM read port.
REQ-015 ram_rdata  input  DATA_WIDTH  RAM read data, valid exactly 1 cycle after ram_re (ddr_simple_dual_port_ram, OUTPUT_REG="TRUE", wclk=rclk=clk).

Function
REQ-016 Write: on push (s_valid && s_ready), same cycle ram_we=1, ram_waddr=wptr, ram_wdata=s_data; wptr increments, wrapping DEPTH-1 -> 0.
REQ-017 ram_cnt (0..DEPTH) = entries written to RAM and not yet read; s_ready = (ram_cnt < DEPTH) && !clr, combinational from registers only (no s_valid dependence).
REQ-018 Output buffer: 2 entries; inflight (0/1) = ram_re issued last cycle.
REQ-019 Prefetch: ram_re=1, ram_raddr=rptr when ram_cnt != 0 && (buf_cnt + inflight - pop) < 2 && !clr; rptr increments with wrap.
REQ-020 Returned ram_rdata is captured into the output buffer in arrival order; m_data = oldest buffer entry; m_valid = (buf_cnt != 0).
REQ-021 Sustained throughput: 1 push and 1 pop per cycle with no bubbles once m_valid is high.
REQ-022 First-word latency: push in cycle N -> ram_re in N+1 -> m_valid high from N+3.
REQ-023 ram_cnt updates: +1 on push, -1 on ram_re, unchanged on both; push in cycle N is readable by prefetch from N+1 (no same-cycle bypass).
REQ-024 level = ram_cnt + inflight + buf_cnt; max DEPTH+2; +1 on push, -1 on pop, unchanged on both.
REQ-025 Full: ram_cnt == DEPTH -> s_ready=0; s_valid held without loss, stall only.
REQ-026 Empty: m_valid=0 and m_ready ignored; m_data holds last value.
REQ-027 clr: at the next edge wptr, rptr, ram_cnt, inflight, buf_cnt, level -> 0; ram_rdata returning the cycle after clr is discarded; push coincident with clr is dropped (s_ready=0).
REQ-028 m_data/m_valid stable while m_valid && !m_ready.

Reset
REQ-029 rstn low: s_ready=0, m_valid=0, m_data=0, level=0, ram_we=0, ram_re=0, ram_waddr=0, ram_raddr=0, ram_wdata=0; all pointers/counters 0.
REQ-030 Reset mid-operation discards all contents; RAM contents are not cleared; the first post-reset ram_rdata is ignored.
REQ-031 s_ready rises in the first cycle after rstn deasserts.

Structure
REQ-032 Package ddr_fifo_pkg holds the RAM read latency constant (1) and the output buffer depth constant (2).
REQ-033 One sub-module, ddr_fifo_out_buf: the 2-entry output buffer with capture/pop and buf_cnt; the RAM is instantiated outside this block.

Verification (ADDR_WIDTH=4, DEPTH=16)
REQ-034 Single push 0xA5 in cycle 0, m_ready=1 -> ram_re in cycle 1, m_valid=1 with m_data=0xA5 in cycle 3, level 1 -> 0 after pop.
REQ-035 m_ready=0, push 0..19 -> 18 accepted (16 RAM + 2 buffer), s_ready=0, level=18; then drain -> 0..17 in order, no loss.
REQ-036 Continuous push and pop of 0..99 -> exactly 1 word out per cycle after the first; wptr/rptr wrap 15 -> 0 with data intact.
REQ-037 level=10 with clr pulsed while s_valid=1 -> next cycle level=0, m_valid=0; later push 0x3C -> output 0x3C only.
REQ-038 rstn asserted mid-stream with level=7 -> all outputs at reset values immediately; after release, push 0x11 -> 0x11 out, no stale data.
REQ-039 Random m_ready (50%) with random s_valid over 10k words -> scoreboard match; m_data stable while stalled.
